// File: rtl/regfile_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter (with helper regfile_wb_fifo)
//  Description : Shares the single RegFile write port between the ALU (A) and
//                load (B) writeback paths. Each path has a 2-entry FIFO, and
//                the oldest head (by 3-bit arrival stamp) wins the port.
//                Equal stamps are resolved by a round-robin pointer.
//  Option      : WBARB_R0_DROP_EN - addr-0 entries are consumed without
//                raising we (wAddr/wData hold).
//  Revision    : 1.0 - initial release
// ============================================================================

// 2-entry FIFO, slot 0 is always the head; entries are {stamp, addr, data}.
module regfile_wb_fifo #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [2:0]        in_stamp,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic [1:0]        count,
   output logic [2:0]        head_stamp,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data
);
   localparam int ENTRY_W = 3 + ADDR_W + DATA_W;

   logic [ENTRY_W-1:0] r_mem [2];
   logic [1:0]         r_count;
   logic               w_wr_idx;

   // Tail slot after an optional pop in the same cycle: count - pop.
   assign w_wr_idx = pop ? r_count[1] : r_count[0];

   // Shift on pop, then write the new entry at the (post-pop) tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_count  <= 2'd0;
      end else begin
         if (pop)
            r_mem[0] <= r_mem[1];
         if (push)
            r_mem[w_wr_idx] <= {in_stamp, in_addr, in_data};
         r_count <= r_count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign count = r_count;
   assign {head_stamp, head_addr, head_data} = r_mem[0];
endmodule

module regfile_wb_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              we,
   output logic [ADDR_W-1:0] wAddr,
   output logic [DATA_W-1:0] wData,
   output logic              busy
);
   logic [1:0]        w_count_a, w_count_b;
   logic [2:0]        w_stamp_a, w_stamp_b;
   logic [ADDR_W-1:0] w_addr_a, w_addr_b, w_sel_addr;
   logic [DATA_W-1:0] w_data_a, w_data_b, w_sel_data;
   logic              w_push_a, w_push_b;
   logic              w_grant_a, w_grant_b;
   logic              w_a_ne, w_b_ne, w_tie, w_a_older, w_tie_grant, w_do_write;
   logic [2:0]        w_diff;
   logic [2:0]        r_stamp;
   logic              r_rr;   // 0 = A wins the next tie, 1 = B

   // Readiness looks at the current count only, so a full FIFO never
   // accepts in the cycle it pops; rst forces both low.
   assign a_ready  = ~rst & (w_count_a != 2'd2);
   assign b_ready  = ~rst & (w_count_b != 2'd2);
   assign w_push_a = a_valid & a_ready;
   assign w_push_b = b_valid & b_ready;

   regfile_wb_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo_a (
      .clk        (clk),
      .rst        (rst),
      .push       (w_push_a),
      .pop        (w_grant_a),
      .in_stamp   (r_stamp),
      .in_addr    (a_addr),
      .in_data    (a_data),
      .count      (w_count_a),
      .head_stamp (w_stamp_a),
      .head_addr  (w_addr_a),
      .head_data  (w_data_a)
   );

   regfile_wb_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo_b (
      .clk        (clk),
      .rst        (rst),
      .push       (w_push_b),
      .pop        (w_grant_b),
      .in_stamp   (r_stamp),
      .in_addr    (b_addr),
      .in_data    (b_data),
      .count      (w_count_b),
      .head_stamp (w_stamp_b),
      .head_addr  (w_addr_b),
      .head_data  (w_data_b)
   );

   // At most 4 live entries keep stamps within a span of 3, so a modular
   // distance of 1..3 from A to B means A is strictly older.
   assign w_a_ne    = (w_count_a != 2'd0);
   assign w_b_ne    = (w_count_b != 2'd0);
   assign w_diff    = w_stamp_b - w_stamp_a;
   assign w_tie     = (w_diff == 3'd0);
   assign w_a_older = (w_diff != 3'd0) && (w_diff <= 3'd3);
   assign w_tie_grant = w_a_ne & w_b_ne & w_tie;

   // Oldest-first grant; ties go to the round-robin pointer.
   always_comb begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
      if (w_a_ne && w_b_ne) begin
         if (w_tie) begin
            w_grant_a = ~r_rr;
            w_grant_b = r_rr;
         end else if (w_a_older) begin
            w_grant_a = 1'b1;
         end else begin
            w_grant_b = 1'b1;
         end
      end else begin
         w_grant_a = w_a_ne;
         w_grant_b = w_b_ne;
      end
   end

   assign w_sel_addr = w_grant_a ? w_addr_a : w_addr_b;
   assign w_sel_data = w_grant_a ? w_data_a : w_data_b;

`ifdef WBARB_R0_DROP_EN
   // Register 0 is hardwired: its slot is consumed but not written.
   assign w_do_write = (w_grant_a | w_grant_b) & (w_sel_addr != '0);
`else
   assign w_do_write = w_grant_a | w_grant_b;
`endif

   // Shared arrival stamp: advances once per cycle that has any push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stamp <= 3'd0;
      else if (w_push_a | w_push_b)
         r_stamp <= r_stamp + 3'd1;
   end

   // Round-robin pointer flips only when it actually settled a tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_rr <= 1'b0;
      else if (w_tie_grant)
         r_rr <= ~r_rr;
   end

   // Registered write port; address/data hold when nothing is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we    <= 1'b0;
         wAddr <= '0;
         wData <= '0;
      end else begin
         we <= w_do_write;
         if (w_do_write) begin
            wAddr <= w_sel_addr;
            wData <= w_sel_data;
         end
      end
   end

   assign busy = w_a_ne | w_b_ne;
endmodule
`default_nettype wire
